// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: EX operand bypass selection (MEM/WB) plus load-use stall
// sequencing for the in-order IF/ID/EX/MEM/WB pipeline. A bubble injected
// into EX/MEM is remembered for one cycle so its stale destination field can
// neither forward nor raise a fresh hazard.
module hazard_fwd_unit #(
  parameter int REG_AW   = 5,  // register address width
  parameter int NUM_SRC  = 2,  // source operands per EX instruction (1..4)
  parameter int LOAD_LAT = 1,  // total stall cycles for a load-use hazard (1..7)
  parameter int ZERO_REG = 1   // 1 = register 0 is hardwired zero
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ext_hold,
  input  logic [NUM_SRC-1:0]        ex_need,
  input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
  input  logic                      mem_valid,
  input  logic                      mem_rwe,
  input  logic                      mem_is_load,
  input  logic [REG_AW-1:0]         mem_rd,
  input  logic                      wb_valid,
  input  logic                      wb_rwe,
  input  logic [REG_AW-1:0]         wb_rd,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      stall,
  output logic                      bubble_mem,
  output logic                      busy
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // WAIT is entered with LOAD_LAT-1 remaining cycles; the IDLE detection
  // cycle is the first stall cycle.
  localparam logic [2:0] CNT_INIT    = 3'(LOAD_LAT - 1);
  localparam bit         MULTI_CYCLE = (LOAD_LAT > 1);

  logic [0:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       bubble_q, bubble_d;

  // Qualified producer conditions shared by every source operand.
  logic mem_eff;
  logic mem_alu_wr;
  logic mem_ld_wr;
  logic wb_wr;
  logic hazard;
  logic [NUM_SRC-1:0] haz_vec;

  // A bubble sitting in EX/MEM carries a stale rd; ignore it entirely.
  assign mem_eff    = mem_valid && !bubble_q;
  assign mem_alu_wr = mem_eff && mem_rwe && !mem_is_load;
  assign mem_ld_wr  = mem_eff && mem_rwe && mem_is_load;
  assign wb_wr      = wb_valid && wb_rwe;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_AW-1:0] rs;
      logic              rs_zero;
      logic              mem_hit;
      logic              wb_hit;

      assign rs      = ex_rs[gi*REG_AW +: REG_AW];
      assign rs_zero = (ZERO_REG != 0) && (rs == '0);
      assign mem_hit = ex_need[gi] && !rs_zero && (mem_rd == rs);
      assign wb_hit  = ex_need[gi] && !rs_zero && wb_wr && (wb_rd == rs);

      // MEM wins over WB; a load in MEM never forwards (data not ready yet),
      // so selection falls through to WB or the register file.
      assign fwd_sel[2*gi +: 2] = (mem_hit && mem_alu_wr) ? 2'b10 :
                                  wb_hit                  ? 2'b01 :
                                                            2'b00;
      assign haz_vec[gi] = mem_hit && mem_ld_wr;
    end
  endgenerate

  assign hazard = |haz_vec;

  // Stall FSM: detect in IDLE, count down remaining load latency in WAIT,
  // and issue exactly one bubble on the final stall cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall      = 1'b0;
    busy       = 1'b0;
    bubble_mem = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall = hazard;
        if (hazard) begin
          if (!MULTI_CYCLE) begin
            bubble_mem = !ext_hold;
          end else if (!ext_hold) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        stall      = 1'b1;
        busy       = 1'b1;
        bubble_mem = (cnt_q == 3'd1) && !ext_hold;
        if (!ext_hold) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bubble marker follows bubble_mem except while the pipeline is frozen.
  always_comb begin
    bubble_d = ext_hold ? bubble_q : bubble_mem;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 3'd0;
      bubble_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bubble_q <= bubble_d;
    end
  end

endmodule
